// File: rtl/layer_pkg.sv
// Shared types and encodings for the layer-0 result writer: memory select codes,
// frame geometry and the pooled-result entry carried through the pool buffer.
package layer_pkg;

    localparam int IMG_W = 64;
    localparam int DW    = 20;
    localparam int AW    = 2 * $clog2(IMG_W);

    localparam logic [2:0] CSEL_IDLE = 3'b000;
    localparam logic [2:0] CSEL_L0K0 = 3'b001;
    localparam logic [2:0] CSEL_L0K1 = 3'b010;
    localparam logic [2:0] CSEL_L1K0 = 3'b011;
    localparam logic [2:0] CSEL_L1K1 = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } wr_state_t;

    typedef struct packed {
        logic [2:0]    csel;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } pool_entry_t;

endpackage

// File: rtl/layer0_writer_pool_fifo.sv
// Two-entry buffer holding pooled results until the shared write port has a free cycle.
// A push into a full buffer is dropped and reported on ovf for one cycle.
module pool_fifo
    import layer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        push,
    input  pool_entry_t push_entry,
    input  logic        pop,
    output pool_entry_t head,
    output logic        full,
    output logic        empty,
    output logic        ovf
);

    logic [1:0]  cnt_q, cnt_d;
    logic        wp_q, wp_d;
    logic        rp_q, rp_d;
    logic        do_push;
    logic        do_pop;
    pool_entry_t mem_q [2];

    always_comb begin
        do_pop  = pop && (cnt_q != 2'd0);
        do_push = push && ((cnt_q != 2'd2) || do_pop);
        ovf     = push && !do_push;
        cnt_d   = cnt_q;
        wp_d    = wp_q ^ do_push;
        rp_d    = rp_q ^ do_pop;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
        if (clr) begin
            cnt_d = 2'd0;
            wp_d  = 1'b0;
            rp_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 2'd0;
            wp_q  <= 1'b0;
            rp_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
        end
    end

    // Storage is pure data: only the occupancy count decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !clr) begin
            mem_q[wp_q] <= push_entry;
        end
    end

    assign head  = mem_q[rp_q];
    assign full  = (cnt_q == 2'd2);
    assign empty = (cnt_q == 2'd0);

endmodule

// File: rtl/layer0_writer.sv
// Layer-0 result writer: ReLU, L0 result writes, on-the-fly 2x2 max-pooling per kernel,
// and pooled L1 writes interleaved into idle cycles of the single write port.
module layer0_writer #(
    parameter int IMG_W = 64,
    parameter int DW    = 20
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_start,
    input  logic                        i_valid,
    input  logic                        i_sel,
    input  logic signed [DW-2:0]        i_data,
    output logic                        o_cwr,
    output logic [2:0]                  o_csel,
    output logic [2*$clog2(IMG_W)-1:0]  o_caddr,
    output logic [DW-1:0]               o_cdata,
    output logic                        o_done,
    output logic                        o_err
);
    import layer_pkg::*;

    localparam int HW    = $clog2(IMG_W) - 1;
    localparam int WIN_W = 2 * HW;
    localparam int ADW   = 2 * $clog2(IMG_W);

    function automatic logic [DW-1:0] relu(input logic signed [DW-2:0] x);
        return x[DW-2] ? '0 : {1'b0, x};
    endfunction

    function automatic logic [DW-1:0] umax(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    wr_state_t            state_q, state_d;
    logic [2:0]           idx_q, idx_d;
    logic [WIN_W-1:0]     win_q, win_d;
    logic [1:0][DW-1:0]   acc_q, acc_d;

    logic                 cwr_q, cwr_d;
    logic [2:0]           csel_q, csel_d;
    logic [ADW-1:0]       caddr_q, caddr_d;
    logic [DW-1:0]        cdata_q, cdata_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic                 take;
    logic                 last_in;
    logic [2:0]           idx_cur;
    logic [WIN_W-1:0]     win_cur;
    logic [HW-1:0]        wr;
    logic [HW-1:0]        wc;
    logic [DW-1:0]        v;
    logic [DW-1:0]        pool_max;
    logic                 push;
    logic                 pop;
    pool_entry_t          push_entry;
    pool_entry_t          fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_ovf;

    // A start pulse restarts counting in the same cycle, so a coincident input is idx 0 of window 0.
    always_comb begin
        take     = i_valid && (i_start || (state_q == S_RUN));
        idx_cur  = i_start ? 3'd0 : idx_q;
        win_cur  = i_start ? '0 : win_q;
        wr       = win_cur[WIN_W-1:HW];
        wc       = win_cur[HW-1:0];
        v        = relu(i_data);
        pool_max = umax(acc_q[idx_cur[0]], v);
        push     = take && (idx_cur[2:1] == 2'b11);
        pop      = !take && !i_start && !fifo_empty;
        last_in  = take && (idx_cur == 3'd7) && (&win_cur);

        push_entry.csel = idx_cur[0] ? CSEL_L1K1 : CSEL_L1K0;
        push_entry.addr = {{(ADW-WIN_W){1'b0}}, wr, wc};
        push_entry.data = pool_max;
    end

    always_comb begin
        idx_d = idx_cur;
        win_d = win_cur;
        acc_d = acc_q;
        if (take) begin
            idx_d = idx_cur + 3'd1;
            if (idx_cur == 3'd7) begin
                win_d = win_cur + 1'b1;
            end
            acc_d[idx_cur[0]] = (idx_cur[2:1] == 2'b00) ? v : pool_max;
        end
    end

    always_comb begin
        state_d = state_q;
        if (i_start) begin
            state_d = S_RUN;
        end else begin
            unique case (state_q)
                S_IDLE:  state_d = S_IDLE;
                S_RUN:   if (last_in) state_d = S_DRAIN;
                S_DRAIN: if (fifo_empty) state_d = S_DONE;
                S_DONE:  state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // L0 writes own the port whenever an input arrives; pooled results fill the gaps.
    always_comb begin
        cwr_d   = take || pop;
        csel_d  = CSEL_IDLE;
        caddr_d = caddr_q;
        cdata_d = cdata_q;
        if (take) begin
            csel_d  = idx_cur[0] ? CSEL_L0K1 : CSEL_L0K0;
            caddr_d = {wr, idx_cur[1], wc, idx_cur[2]};
            cdata_d = v;
        end else if (pop) begin
            csel_d  = fifo_head.csel;
            caddr_d = fifo_head.addr;
            cdata_d = fifo_head.data;
        end
        done_d = (state_d == S_DONE);
        err_d  = err_q || fifo_ovf || (take && (i_sel != idx_cur[0]));
    end

    pool_fifo u_pool_fifo (
        .clk        (clk),
        .reset      (reset),
        .clr        (i_start),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .ovf        (fifo_ovf)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            win_q   <= '0;
            cwr_q   <= 1'b0;
            csel_q  <= CSEL_IDLE;
            caddr_q <= '0;
            cdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            win_q   <= win_d;
            cwr_q   <= cwr_d;
            csel_q  <= csel_d;
            caddr_q <= caddr_d;
            cdata_q <= cdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Accumulators are reloaded at idx 0/1 of every window, so they need no reset.
    always_ff @(posedge clk) begin
        acc_q <= acc_d;
    end

    assign o_cwr   = cwr_q;
    assign o_csel  = csel_q;
    assign o_caddr = caddr_q;
    assign o_cdata = cdata_q;
    assign o_done  = done_q;
    assign o_err   = err_q;

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_layer0_writer.sv
// Directed bench for layer0_writer: hand-computed single-window writes, error paths,
// reset abort and a full frame against a small behavioural model.
module tb_layer0_writer;

    logic               clk = 1'b0;
    logic               reset;
    logic               i_start;
    logic               i_valid;
    logic               i_sel;
    logic signed [18:0] i_data;
    logic               o_cwr;
    logic [2:0]         o_csel;
    logic [11:0]        o_caddr;
    logic [19:0]        o_cdata;
    logic               o_done;
    logic               o_err;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    int last_wr_cyc = 0;
    int done_cyc    = 0;
    bit done_seen   = 1'b0;
    logic [34:0] wlog [$];
    logic [34:0] exp_q [$];

    layer0_writer #(.IMG_W(64), .DW(20)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_start (i_start),
        .i_valid (i_valid),
        .i_sel   (i_sel),
        .i_data  (i_data),
        .o_cwr   (o_cwr),
        .o_csel  (o_csel),
        .o_caddr (o_caddr),
        .o_cdata (o_cdata),
        .o_done  (o_done),
        .o_err   (o_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_cwr) begin
            wlog.push_back({o_csel, o_caddr, o_cdata});
            last_wr_cyc = cyc;
        end
        if (reset) done_seen = 1'b0;
        else if (o_done && !done_seen) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
        end
    end

    task automatic chk_vec(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [34:0] ent(input int csel, input int addr, input int data);
        logic [34:0] e;
        e = {csel[2:0], addr[11:0], data[19:0]};
        return e;
    endfunction

    function automatic logic [34:0] logv(input int i);
        if (i < wlog.size()) return wlog[i];
        return '1;
    endfunction

    task automatic drive(input bit v, input bit s, input int d, input bit st);
        i_valid = v;
        i_sel   = s;
        i_data  = d[18:0];
        i_start = st;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_start = 1'b0;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        i_valid = 1'b0;
        i_start = 1'b0;
        i_sel   = 1'b0;
        i_data  = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    int tbl [8] = '{5, -3, 7, 2, -1, 9, 4, 4};

    initial begin
        int base;
        logic [34:0] ex [10];

        // Reset state
        reset = 1'b1; i_valid = 0; i_start = 0; i_sel = 0; i_data = '0;
        @(negedge clk);
        chk_vec("rst_cwr",   o_cwr,   0);
        chk_vec("rst_csel",  o_csel,  0);
        chk_vec("rst_caddr", o_caddr, 0);
        chk_vec("rst_cdata", o_cdata, 0);
        chk_vec("rst_done",  o_done,  0);
        chk_vec("rst_err",   o_err,   0);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;

        // Valid in IDLE is ignored; start coincident with valid is idx 0 of window 0
        base = wlog.size();
        drive(1, 0, 77, 0);
        drive(1, 0, 123, 1);
        drive(1, 1, -5, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk_vec("start_cnt", wlog.size() - base, 2);
        chk_vec("start_wr0", logv(base + 0), ent(1, 0, 123));
        chk_vec("start_wr1", logv(base + 1), ent(2, 0, 0));
        chk_vec("start_err", o_err, 0);

        // Single window with hand-computed L0 and pooled results
        do_reset();
        base = wlog.size();
        drive(0, 0, 0, 1);
        for (int i = 0; i < 8; i++) drive(1, i[0], tbl[i], 0);
        repeat (6) drive(0, 0, 0, 0);
        ex[0] = ent(1, 0, 5);  ex[1] = ent(2, 0, 0);
        ex[2] = ent(1, 64, 7); ex[3] = ent(2, 64, 2);
        ex[4] = ent(1, 1, 0);  ex[5] = ent(2, 1, 9);
        ex[6] = ent(1, 65, 4); ex[7] = ent(2, 65, 4);
        ex[8] = ent(3, 0, 7);  ex[9] = ent(4, 0, 9);
        chk_vec("win_cnt", wlog.size() - base, 10);
        for (int i = 0; i < 10; i++) chk_vec($sformatf("win_wr%0d", i), logv(base + i), ex[i]);
        chk_vec("win_err",   o_err,   0);
        chk_vec("win_done",  o_done,  0);
        chk_vec("idle_cwr",  o_cwr,   0);
        chk_vec("idle_csel", o_csel,  0);
        chk_vec("idle_addr", o_caddr, 0);
        chk_vec("idle_data", o_cdata, 9);

        // Kernel order violation at idx 3
        do_reset();
        base = wlog.size();
        drive(0, 0, 0, 1);
        for (int i = 0; i < 8; i++) begin
            drive(1, (i == 3) ? 1'b0 : i[0], tbl[i], 0);
            if (i == 2) chk_vec("sel_err_pre",  o_err, 0);
            if (i == 3) chk_vec("sel_err_post", o_err, 1);
        end
        repeat (6) drive(0, 0, 0, 0);
        chk_vec("sel_wr3", logv(base + 3), ent(2, 64, 2));
        chk_vec("sel_err_hold", o_err, 1);

        // Continuous input overflows the pool buffer on the third push
        do_reset();
        drive(0, 0, 0, 1);
        for (int i = 0; i < 24; i++) begin
            drive(1, i[0], 1, 0);
            if (i == 13) chk_vec("ovf_pre",  o_err, 0);
            if (i == 14) chk_vec("ovf_post", o_err, 1);
        end
        drive(0, 0, 0, 0);
        chk_vec("ovf_hold", o_err, 1);

        // Reset mid-frame with two pooled entries pending
        do_reset();
        base = wlog.size();
        drive(0, 0, 0, 1);
        for (int i = 0; i < 8; i++) drive(1, i[0], tbl[i], 0);
        #5 reset = 1'b1;
        @(negedge clk);
        chk_vec("abort_cwr",   o_cwr,   0);
        chk_vec("abort_csel",  o_csel,  0);
        chk_vec("abort_caddr", o_caddr, 0);
        chk_vec("abort_cdata", o_cdata, 0);
        chk_vec("abort_done",  o_done,  0);
        chk_vec("abort_err",   o_err,   0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (5) drive(0, 0, 0, 0);
        chk_vec("abort_cnt", wlog.size() - base, 8);

        // Full frame, 8-on/4-off cadence, against the behavioural model
        base = wlog.size();
        drive(0, 0, 0, 1);
        for (int w = 0; w < 1024; w++) begin
            int m0, m1, wr, wc;
            m0 = 0; m1 = 0;
            wr = w / 32; wc = w % 32;
            for (int i = 0; i < 8; i++) begin
                int d, r, row, col;
                d = ((w * 8 + i) * 53 % 2000) - 700;
                r = (d < 0) ? 0 : d;
                row = 2 * wr + ((i >> 1) & 1);
                col = 2 * wc + ((i >> 2) & 1);
                exp_q.push_back(ent((i % 2 == 1) ? 2 : 1, row * 64 + col, r));
                if (i % 2 == 0) m0 = (r > m0) ? r : m0;
                else            m1 = (r > m1) ? r : m1;
                drive(1, i[0], d, 0);
            end
            exp_q.push_back(ent(3, w, m0));
            exp_q.push_back(ent(4, w, m1));
            repeat (4) drive(0, 0, 0, 0);
        end
        for (int k = 0; k < 40 && !o_done; k++) drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk_vec("frame_done", o_done, 1);
        chk_vec("frame_done_lat", done_cyc - last_wr_cyc, 1);
        chk_vec("frame_err", o_err, 0);
        chk_vec("frame_cnt", wlog.size() - base, 10240);
        for (int i = 0; i < exp_q.size(); i++)
            chk_vec($sformatf("frame_wr%0d", i), logv(base + i), exp_q[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
